nn_score_sequencer: RTL and testbench

//  Sequences one shared FP16->fixed-point converter across the 10 NN class scores written by the

---
 rtl/nn_score_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_nn_score_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_score_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nn_score_sequencer
// Description : Shares one FP16->fixed-point converter across N_CH class
//               scores. On start it snapshots all scores and issues them to
//               the converter in order. It collects the in-order results and
//               tracks the running signed argmax. All results and the
//               predicted digit are then committed in a single cycle.
// Ports       : Clk, Reset (async, active-high)
//               start, abort              pass control
//               fp_in                     N_CH packed FP16 scores
//               cvt_in_data/valid/ready   operand channel to converter
//               cvt_out_data/valid        result channel (no backpressure)
//               fixed_out, digit          committed results and argmax
//               done, busy, err_spurious  status
// Revision    : 1.0  initial release
// ============================================================================
module nn_score_sequencer #(
    parameter int N_CH  = 10,
    parameter int W     = 16,
    parameter int IDX_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N_CH*W-1:0] fp_in,
    output logic [W-1:0]      cvt_in_data,
    output logic              cvt_in_valid,
    input  logic              cvt_in_ready,
    input  logic [W-1:0]      cvt_out_data,
    input  logic              cvt_out_valid,
    output logic [N_CH*W-1:0] fixed_out,
    output logic [IDX_W-1:0]  digit,
    output logic              done,
    output logic              busy,
    output logic              err_spurious
);
    localparam int CNT_W = $clog2(N_CH + 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue  = 3'd1;
    localparam logic [2:0] c_st_drain  = 3'd2;
    localparam logic [2:0] c_st_commit = 3'd3;
    localparam logic [2:0] c_st_flush  = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [W-1:0]     r_in_buf [N_CH];
    logic [W-1:0]     r_res    [N_CH];
    logic [W-1:0]     r_fixed  [N_CH];
    logic [CNT_W-1:0] r_iss;
    logic [CNT_W-1:0] r_ret;
    logic [W-1:0]     r_best_val;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_digit;
    logic             r_cvt_in_valid;
    logic             r_done;
    logic             r_err_spurious;

    logic [W-1:0]     w_fp [N_CH];
    logic             w_active;
    logic             w_xfer;
    logic [CNT_W-1:0] w_outst;
    logic             w_spur;
    logic             w_cap;
    logic             w_flush_cap;
    logic             w_new_best;
    logic [W-1:0]     w_best_val_nx;
    logic [IDX_W-1:0] w_best_idx_nx;
    logic             w_abort;
    logic             w_last_cap;
    logic             w_flush_empty;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_chan
            assign w_fp[k]             = fp_in[k*W +: W];
            assign fixed_out[k*W +: W] = r_fixed[k];
        end
    endgenerate

    assign w_active    = (r_state == c_st_issue) | (r_state == c_st_drain);
    assign w_xfer      = r_cvt_in_valid & cvt_in_ready;
    assign w_outst     = r_iss - r_ret;
    // A result with nothing outstanding is flagged and never stored or counted.
    assign w_spur      = cvt_out_valid & (w_outst == '0);
    assign w_cap       = cvt_out_valid & ~w_spur & w_active;
    assign w_flush_cap = cvt_out_valid & ~w_spur & (r_state == c_st_flush);

    // Strict greater-than keeps the lower index on ties.
    assign w_new_best    = (r_ret == '0) | ($signed(cvt_out_data) > $signed(r_best_val));
    assign w_best_val_nx = w_new_best ? cvt_out_data : r_best_val;
    assign w_best_idx_nx = w_new_best ? IDX_W'(r_ret) : r_best_idx;

    assign w_abort       = abort & w_active;
    assign w_last_cap    = w_cap & (r_state == c_st_drain) & (r_ret == c_cnt_last);
    // Leave FLUSH once nothing will be outstanding after this cycle.
    assign w_flush_empty = (w_outst == '0) | (w_flush_cap & (w_outst == c_cnt_one));

    // r_iss only indexes the buffer while valid is high (r_iss < N_CH).
    assign cvt_in_data  = r_in_buf[r_iss];
    assign cvt_in_valid = r_cvt_in_valid;
    assign digit        = r_digit;
    assign done         = r_done;
    assign busy         = (r_state != c_st_idle);
    assign err_spurious = r_err_spurious;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= c_st_idle;
            r_iss          <= '0;
            r_ret          <= '0;
            r_best_val     <= '0;
            r_best_idx     <= '0;
            r_digit        <= '0;
            r_cvt_in_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err_spurious <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                r_in_buf[k] <= '0;
                r_res[k]    <= '0;
                r_fixed[k]  <= '0;
            end
        end else begin
            r_done <= 1'b0;

            if (w_xfer) begin
                r_iss <= r_iss + c_cnt_one;
            end
            if (w_cap) begin
                r_res[r_ret] <= cvt_out_data;
                r_best_val   <= w_best_val_nx;
                r_best_idx   <= w_best_idx_nx;
            end
            if (w_cap | w_flush_cap) begin
                r_ret <= r_ret + c_cnt_one;
            end
            if (w_spur) begin
                r_err_spurious <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        for (int k = 0; k < N_CH; k++) begin
                            r_in_buf[k] <= w_fp[k];
                        end
                        r_iss          <= '0;
                        r_ret          <= '0;
                        r_err_spurious <= 1'b0;
                        r_cvt_in_valid <= 1'b1;
                        r_state        <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (w_abort) begin
                        r_cvt_in_valid <= 1'b0;
                        r_state        <= c_st_flush;
                    end else if (w_xfer && (r_iss == c_cnt_last)) begin
                        r_cvt_in_valid <= 1'b0;
                        r_state        <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_abort) begin
                        r_state <= c_st_flush;
                    end else if (w_last_cap) begin
                        // The final result bypasses r_res so that the
                        // committed values and done appear together.
                        for (int k = 0; k < N_CH - 1; k++) begin
                            r_fixed[k] <= r_res[k];
                        end
                        r_fixed[N_CH-1] <= cvt_out_data;
                        r_digit         <= w_best_idx_nx;
                        r_done          <= 1'b1;
                        r_state         <= c_st_commit;
                    end
                end
                c_st_commit: begin
                    r_state <= c_st_idle;
                end
                c_st_flush: begin
                    if (w_flush_empty) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_cvt_in_valid <= 1'b0;
                    r_state        <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_score_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nn_score_sequencer
// Description : Self-checking bench for nn_score_sequencer. A behavioural
//               converter with configurable latency answers the DUT. The
//               expected fixed-point results and argmax are computed directly
//               from the chosen scores.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nn_score_sequencer;
    localparam int N_CH  = 10;
    localparam int W     = 16;
    localparam int IDX_W = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              start;
    logic              abort;
    logic [N_CH*W-1:0] fp_in;
    logic [W-1:0]      cvt_in_data;
    logic              cvt_in_valid;
    logic              cvt_in_ready;
    logic [W-1:0]      cvt_out_data;
    logic              cvt_out_valid;
    logic [N_CH*W-1:0] fixed_out;
    logic [IDX_W-1:0]  digit;
    logic              done;
    logic              busy;
    logic              err_spurious;

    nn_score_sequencer #(.N_CH(N_CH), .W(W), .IDX_W(IDX_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .abort        (abort),
        .fp_in        (fp_in),
        .cvt_in_data  (cvt_in_data),
        .cvt_in_valid (cvt_in_valid),
        .cvt_in_ready (cvt_in_ready),
        .cvt_out_data (cvt_out_data),
        .cvt_out_valid(cvt_out_valid),
        .fixed_out    (fixed_out),
        .digit        (digit),
        .done         (done),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int           due;
        logic [W-1:0] d;
    } res_t;

    res_t              pipe [$];
    logic [W-1:0]      sc [N_CH];
    logic [N_CH*W-1:0] prev_fixed;
    int                prev_digit;
    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int rc = 0;
    int lat = 1;
    int rmode = 0;
    logic inject_spur = 1'b0;
    int done_cnt, done_rc, busy_low, xfer_cnt, first_xfer_rc, last_xfer_rc;
    int order_err, res_cnt, last_res_rc, busy_fall_rc;
    int a_rc, r_last;

    // Behavioural converter: a fixed bijection, its own inverse.
    function automatic logic [W-1:0] cvt(input logic [W-1:0] x);
        return x ^ 16'h5A5A;
    endfunction

    function automatic logic [N_CH*W-1:0] exp_fixed();
        logic [N_CH*W-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*W +: W] = cvt(sc[k]);
        return v;
    endfunction

    function automatic int exp_digit();
        int best;
        logic signed [W-1:0] bv, v;
        best = 0;
        bv = cvt(sc[0]);
        for (int k = 1; k < N_CH; k++) begin
            v = cvt(sc[k]);
            if (v > bv) begin
                bv = v;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic check(input string tag, input logic [N_CH*W-1:0] obs,
                         input logic [N_CH*W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic step();
        res_t r;
        case (rmode)
            0: cvt_in_ready = 1'b1;
            1: cvt_in_ready = (rc % 2 == 1);
            2: cvt_in_ready = 1'($urandom_range(0, 1));
            default: cvt_in_ready = 1'b0;
        endcase
        cvt_out_valid = 1'b0;
        cvt_out_data  = '0;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            r = pipe.pop_front();
            cvt_out_valid = 1'b1;
            cvt_out_data  = r.d;
            res_cnt++;
            last_res_rc = rc;
        end
        if (inject_spur) begin
            cvt_out_valid = 1'b1;
            cvt_out_data  = 16'hDEAD;
        end
        #1;
        if (cvt_in_valid && cvt_in_ready) begin
            pipe.push_back('{cyc + lat, cvt(cvt_in_data)});
            if (xfer_cnt >= N_CH || cvt_in_data !== sc[xfer_cnt]) order_err++;
            if (xfer_cnt == 0) first_xfer_rc = rc;
            last_xfer_rc = rc;
            xfer_cnt++;
        end
        if (!busy && rc >= 1 && done_cnt == 0) busy_low++;
        if (!busy && rc >= 1 && busy_fall_rc < 0) busy_fall_rc = rc;
        if (done) begin
            done_cnt++;
            done_rc = rc;
        end
        @(posedge Clk);
        #1;
        cyc++;
        rc++;
    endtask

    task automatic begin_pass();
        for (int k = 0; k < N_CH; k++) fp_in[k*W +: W] = sc[k];
        done_cnt = 0; done_rc = -1; busy_low = 0; xfer_cnt = 0;
        first_xfer_rc = -1; last_xfer_rc = -1; order_err = 0;
        res_cnt = 0; last_res_rc = -1; busy_fall_rc = -1;
        rc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        while (done_cnt == 0 && rc < budget) step();
        step();
        step();
    endtask

    task automatic check_commit(input string tag);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_fixed"}, fixed_out, exp_fixed());
        check({tag, "_digit"}, digit, exp_digit());
        check({tag, "_err"}, err_spurious, 0);
        prev_fixed = exp_fixed();
        prev_digit = exp_digit();
    endtask

    task automatic rand_scores();
        for (int k = 0; k < N_CH; k++) sc[k] = W'($urandom);
    endtask

    initial begin
        int t1 [N_CH];
        t1 = '{5, -2, 9, 9, 0, 1, -7, 3, 2, 8};
        Reset = 1'b1; start = 1'b0; abort = 1'b0; fp_in = '0;
        cvt_in_ready = 1'b0; cvt_out_valid = 1'b0; cvt_out_data = '0;
        prev_fixed = '0; prev_digit = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_fixed", fixed_out, 0);
        check("rst_digit", digit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", cvt_in_valid, 0);
        check("rst_err", err_spurious, 0);
        Reset = 1'b0;

        // Known scores, ready high, latency 3.
        for (int k = 0; k < N_CH; k++) sc[k] = cvt(W'(t1[k]));
        rmode = 0; lat = 3;
        begin_pass();
        run_to_done(60);
        check("t1_done_cycle", done_rc, 14);
        check("t1_digit_tie", digit, 2);
        check_commit("t1");

        // Ready toggling, shortest latency.
        rand_scores();
        rmode = 1; lat = 1;
        begin_pass();
        run_to_done(80);
        check("t2_xfer_span", last_xfer_rc - first_xfer_rc + 1, 19);
        check("t2_order", order_err, 0);
        check("t2_busy", busy_low, 0);
        check_commit("t2");

        // All results most-negative.
        for (int k = 0; k < N_CH; k++) sc[k] = cvt(16'h8000);
        rmode = 0; lat = 2;
        begin_pass();
        run_to_done(60);
        check("t3_digit", digit, 0);
        check_commit("t3");

        // Abort after exactly four transfers, latency 5.
        rand_scores();
        rmode = 0; lat = 5;
        begin_pass();
        repeat (4) step();
        rmode = 3;
        abort = 1'b1;
        step();
        abort = 1'b0;
        while (busy_fall_rc < 0 && rc < 60) step();
        repeat (2) step();
        check("t4_absorbed", res_cnt, 4);
        check("t4_pipe_empty", pipe.size(), 0);
        check("t4_busy_fall", busy_fall_rc, 4 + lat + 1);
        check("t4_no_done", done_cnt, 0);
        check("t4_keep_fixed", fixed_out, prev_fixed);
        check("t4_keep_digit", digit, prev_digit);
        check("t4_err", err_spurious, 0);

        // Random aborts while still issuing.
        for (int it = 0; it < 4; it++) begin
            rand_scores();
            rmode = 2; lat = $urandom_range(1, 6);
            a_rc = $urandom_range(1, 9);
            begin_pass();
            while (rc < a_rc) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            while (busy_fall_rc < 0 && rc < 80) step();
            while (pipe.size() > 0 && rc < 100) step();
            r_last = (last_res_rc > a_rc) ? last_res_rc : a_rc + 1;
            check("ra_busy_fall", busy_fall_rc, r_last + 1);
            check("ra_no_done", done_cnt, 0);
            check("ra_keep_fixed", fixed_out, prev_fixed);
            check("ra_err", err_spurious, 0);
        end

        // Start mid-pass is ignored; fp_in changes after start are not seen.
        rand_scores();
        rmode = 2; lat = $urandom_range(1, 4);
        begin_pass();
        repeat (4) step();
        fp_in = {N_CH{16'hBEEF}};
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(120);
        check("t5_order", order_err, 0);
        check_commit("t5");

        // Spurious result in IDLE, cleared by the next start.
        rmode = 3;
        inject_spur = 1'b1;
        step();
        inject_spur = 1'b0;
        check("t6_err_set", err_spurious, 1);
        check("t6_keep_fixed", fixed_out, prev_fixed);
        rand_scores();
        rmode = 0; lat = 2;
        begin_pass();
        check("t6_err_clr", err_spurious, 0);
        run_to_done(60);
        check_commit("t6");

        // Reset in DRAIN.
        rand_scores();
        rmode = 0; lat = 5;
        begin_pass();
        while (rc < 12) step();
        #2;
        Reset = 1'b1;
        #1;
        check("t7_fixed", fixed_out, 0);
        check("t7_digit", digit, 0);
        check("t7_busy", busy, 0);
        check("t7_valid", cvt_in_valid, 0);
        cvt_out_valid = 1'b0;
        pipe.delete();
        @(posedge Clk);
        #1;
        cyc++;
        Reset = 1'b0;
        prev_fixed = '0; prev_digit = 0;
        rand_scores();
        rmode = 2; lat = 3;
        begin_pass();
        run_to_done(120);
        check("t7_order", order_err, 0);
        check_commit("t7");

        // Random full passes.
        for (int it = 0; it < 3; it++) begin
            rand_scores();
            rmode = 2; lat = $urandom_range(1, 6);
            begin_pass();
            run_to_done(150);
            check("rp_order", order_err, 0);
            check_commit("rp");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
